// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like memory port between the fetch (inst) and memory-stage (data) requesters.
// Responses come back in order; a small FIFO of owner IDs steers each one to its requester.
module sram_port_arbiter #(
    parameter int MAX_OUT = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         inst_req,
    input  logic [AW-1:0]                inst_addr,
    output logic                         inst_addr_ok,
    output logic                         inst_data_ok,
    output logic [DW-1:0]                inst_rdata,
    input  logic                         data_req,
    input  logic                         data_wr,
    input  logic [DW/8-1:0]              data_wstrb,
    input  logic [AW-1:0]                data_addr,
    input  logic [DW-1:0]                data_wdata,
    output logic                         data_addr_ok,
    output logic                         data_data_ok,
    output logic [DW-1:0]                data_rdata,
    output logic                         mem_req,
    output logic                         mem_wr,
    output logic [DW/8-1:0]              mem_wstrb,
    output logic [AW-1:0]                mem_addr,
    output logic [DW-1:0]                mem_wdata,
    input  logic                         mem_addr_ok,
    input  logic                         mem_data_ok,
    input  logic [DW-1:0]                mem_rdata,
    output logic [1:0]                   dbg_state,
    output logic [$clog2(MAX_OUT+1)-1:0] dbg_cnt
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOCK_INST = 2'd1,
        ST_LOCK_DATA = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [MAX_OUT-1:0] ids;

    logic owner_data;
    logic owner_req;
    logic full;
    logic push;
    logic pop;
    logic head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
    endfunction

    // A stalled address phase pins the owner so the address stays stable until accepted.
    assign owner_data = (state == ST_IDLE) ? data_req : (state == ST_LOCK_DATA);
    assign owner_req  = owner_data ? data_req : inst_req;
    assign full       = (cnt == CW'(MAX_OUT));

    assign mem_req   = resetn && owner_req && !full;
    assign mem_wr    = owner_data ? data_wr    : 1'b0;
    assign mem_wstrb = owner_data ? data_wstrb : '0;
    assign mem_addr  = owner_data ? data_addr  : inst_addr;
    assign mem_wdata = owner_data ? data_wdata : '0;

    assign push = mem_req && mem_addr_ok;
    assign pop  = mem_data_ok && (cnt != '0);
    assign head = ids[rd_ptr];

    assign inst_addr_ok = push && !owner_data;
    assign data_addr_ok = push && owner_data;
    assign inst_data_ok = pop && !head;
    assign data_data_ok = pop && head;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign dbg_state = state;
    assign dbg_cnt   = cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else if (mem_req) begin
            if (mem_addr_ok) begin
                state <= ST_IDLE;
            end else begin
                state <= owner_data ? ST_LOCK_DATA : ST_LOCK_INST;
            end
        end else if (!owner_req) begin
            // Locked owner withdrew its request: release rather than wait forever.
            state <= ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ids    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                ids[wr_ptr] <= owner_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule
